// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-programmable serial bit-pattern detector.
// Patterns of 1..MAX_LEN bits, overlapping or non-overlapping matching,
// registered one-cycle match pulse and a saturating match counter.
// Optional build macro SEQ_DET_WILDCARD_EN adds a per-bit care_mask input
// that is latched with the configuration; masked-out positions always match.
//
// state | meaning
// UNCFG | no valid configuration held, serial input ignored
// RUN   | configuration held, detecting on every in_valid cycle

module seq_detector_param #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               x,
  input  logic               in_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               overlap,
`ifdef SEQ_DET_WILDCARD_EN
  input  logic [MAX_LEN-1:0] care_mask,
`endif
  input  logic               clr_count,
  output logic               y,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err,
  output logic               armed
);

  typedef enum logic {UNCFG = 1'b0, RUN = 1'b1} state_t;

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               y_q, y_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
`ifdef SEQ_DET_WILDCARD_EN
  logic [MAX_LEN-1:0] mask_q, mask_d;
`endif

  logic [MAX_LEN-1:0] hist_nx;
  logic [LEN_W-1:0]   fill_inc;
  logic [MAX_LEN-1:0] len_mask;
  logic [MAX_LEN-1:0] cmp_mask;
  logic               load_legal;
  logic               shift_en;
  logic               match;

  // Candidate history/fill for a valid bit and the set of compared positions
  always_comb begin
    hist_nx  = {hist_q[MAX_LEN-2:0], x};
    fill_inc = (fill_q == MAX_LEN_L) ? fill_q : fill_q + 1'b1;
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
`ifdef SEQ_DET_WILDCARD_EN
    cmp_mask = len_mask & mask_q;
`else
    cmp_mask = len_mask;
`endif
    load_legal = (pat_len != '0) && (pat_len <= MAX_LEN_L);
    // A load in the same cycle as a valid bit wins; the bit is dropped.
    shift_en   = (state_q == RUN) && in_valid && !cfg_load;
    match      = shift_en && (fill_inc >= len_q) &&
                 (((hist_nx ^ pat_q) & cmp_mask) == '0);
  end

  // Next-state, configuration, history and counter update
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    y_d     = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
`ifdef SEQ_DET_WILDCARD_EN
    mask_d  = mask_q;
`endif

    if (cfg_load) begin
      if (load_legal) begin
        state_d = RUN;
        pat_d   = pattern;
        len_d   = pat_len;
        ovl_d   = overlap;
        hist_d  = '0;
        fill_d  = '0;
`ifdef SEQ_DET_WILDCARD_EN
        mask_d  = care_mask;
`endif
      end else begin
        err_d = 1'b1;
      end
    end else if (shift_en) begin
      hist_d = hist_nx;
      fill_d = (match && !ovl_q) ? '0 : fill_inc;
      y_d    = match;
    end

    // Clear takes priority over a coincident match; the pulse still fires.
    if (clr_count) begin
      cnt_d = '0;
    end else if (match && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State and datapath registers, asynchronously reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= UNCFG;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      hist_q  <= '0;
      fill_q  <= '0;
      y_q     <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef SEQ_DET_WILDCARD_EN
      mask_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      y_q     <= y_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
`ifdef SEQ_DET_WILDCARD_EN
      mask_q  <= mask_d;
`endif
    end
  end

  assign y           = y_q;
  assign match_count = cnt_q;
  assign cfg_err     = err_q;
  assign armed       = (state_q == RUN);

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param (MAX_LEN=8, LEN_W=4, CNT_W=2).
module tb_seq_detector_param;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic               x;
  logic               in_valid;
  logic               cfg_load;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   pat_len;
  logic               overlap;
  logic               clr_count;
  logic               y;
  logic [CNT_W-1:0]   match_count;
  logic               cfg_err;
  logic               armed;
`ifdef SEQ_DET_WILDCARD_EN
  logic [MAX_LEN-1:0] care_mask = '1;
`endif

  int checks   = 0;
  int failures = 0;

  seq_detector_param #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .x           (x),
    .in_valid    (in_valid),
    .cfg_load    (cfg_load),
    .pattern     (pattern),
    .pat_len     (pat_len),
    .overlap     (overlap),
`ifdef SEQ_DET_WILDCARD_EN
    .care_mask   (care_mask),
`endif
    .clr_count   (clr_count),
    .y           (y),
    .match_count (match_count),
    .cfg_err     (cfg_err),
    .armed       (armed)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock with the current inputs; returns #1 after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    x = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_load(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l, input logic o);
    pattern  = p;
    pat_len  = l;
    overlap  = o;
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic do_clear();
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
  endtask

  logic [6:0] stream7 = 7'b1011011;   // bit 6 sent first
  logic [6:0] exp_ovl = 7'b0001001;   // expected y per bit, bit 6 first
  logic [6:0] exp_nov = 7'b0001000;
  logic [3:0] pat4    = 4'b1011;
  logic [3:0] exp4    = 4'b0001;

  initial begin
    reset = 1'b1; x = 1'b0; in_valid = 1'b0; cfg_load = 1'b0;
    pattern = '0; pat_len = '0; overlap = 1'b0; clr_count = 1'b0;
    tick(); tick();
    check_val("rst_y", y, 0);
    check_val("rst_cnt", match_count, 0);
    check_val("rst_err", cfg_err, 0);
    check_val("rst_armed", armed, 0);
    reset = 1'b0;
    tick();

    // 1: unconfigured detector ignores the stream
    for (int i = 0; i < 10; i++) begin
      send_bit(1'b1);
      check_val("uncfg_y", y, 0);
      check_val("uncfg_armed", armed, 0);
      check_val("uncfg_cnt", match_count, 0);
    end

    // 2: overlapping 1011
    do_load(8'b0000_1011, 4'd4, 1'b1);
    check_val("load_armed", armed, 1);
    check_val("load_err", cfg_err, 0);
    for (int i = 6; i >= 0; i--) begin
      send_bit(stream7[i]);
      check_val("ovl_y", y, exp_ovl[i]);
    end
    check_val("ovl_cnt", match_count, 2);

    // 3: same stream non-overlapping
    do_clear();
    check_val("clr_cnt", match_count, 0);
    do_load(8'b0000_1011, 4'd4, 1'b0);
    for (int i = 6; i >= 0; i--) begin
      send_bit(stream7[i]);
      check_val("nov_y", y, exp_nov[i]);
    end
    check_val("nov_cnt", match_count, 1);

    // 4: illegal loads pulse cfg_err and keep the old config
    do_load(8'hFF, 4'd0, 1'b1);
    check_val("len0_err", cfg_err, 1);
    check_val("len0_armed", armed, 1);
    tick();
    check_val("err_pulse", cfg_err, 0);
    do_load(8'hFF, 4'd9, 1'b1);
    check_val("len9_err", cfg_err, 1);
    for (int i = 3; i >= 0; i--) begin
      send_bit(pat4[i]);
      check_val("old_cfg_y", y, exp4[i]);
    end
    check_val("old_cfg_cnt", match_count, 2);

    // load with a coincident valid bit: bit dropped, no match
    do_clear();
    x = 1'b1;
    in_valid = 1'b1;
    do_load(8'b0000_0001, 4'd1, 1'b0);
    in_valid = 1'b0;
    check_val("ld_drop_y", y, 0);
    tick();
    check_val("ld_drop_y2", y, 0);
    check_val("ld_drop_cnt", match_count, 0);

    // 5: len=1, saturation at 3, clear on a match cycle
    for (int i = 1; i <= 6; i++) begin
      send_bit(1'b1);
      check_val("len1_y", y, 1);
      check_val("sat_cnt", match_count, (i > 3) ? 3 : i);
    end
    send_bit(1'b0);
    check_val("len1_zero_y", y, 0);
    clr_count = 1'b1;
    send_bit(1'b1);
    clr_count = 1'b0;
    check_val("clr_match_y", y, 1);
    check_val("clr_match_cnt", match_count, 0);

    // 6: gaps are ignored, reset mid-stream is immediate
    do_load(8'b0000_1011, 4'd4, 1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    x = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("gap_y", y, 0);
    end
    send_bit(1'b1);
    check_val("gap_y3", y, 0);
    send_bit(1'b1);
    check_val("gap_match_y", y, 1);
    check_val("gap_cnt", match_count, 1);
    x = 1'b1;
    in_valid = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check_val("async_y", y, 0);
    check_val("async_armed", armed, 0);
    check_val("async_cnt", match_count, 0);
    in_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    for (int i = 3; i >= 0; i--) begin
      send_bit(pat4[i]);
      check_val("post_rst_y", y, 0);
    end
    check_val("post_rst_armed", armed, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
